swipt_duty_tx: RTL and testbench
================================

// Module: swipt_duty_tx
// PURPOSE
//  Data transmitter for the SWIPT link: encodes bytes as duty-cycle (l) steps on the power carrier.
//  Drives l_out into SwiptOut in place of a static duty value; the current-sensing Data block on the ADC path decodes the steps.
//  Frame = preamble, 8 data bits LSB first, optional parity bit, stop. One bit period per symbol.
// PARAMETERS
//  BIT_CYCLES     1000    clk cycles per symbol (10 us at 100 MHz); must be >= 2
//  PREAMBLE_BITS  4       preamble symbols, alternating 1,0,1,0...; must be >= 1
//  DEFAULT_L      12'hC8  l_out value in reset
// PORTS
//  clk         in   1   system clock
//  nrst        in   1   asynchronous active-low reset
//  swiptAlive  in   1   heartbeat-qualified carrier-on flag
//  enable      in   1   transmitter enable (low = comms/idle control)
//  base_l      in   12  idle duty value
//  delta_l     in   12  modulation depth
//  tx_data     in   8   byte to send
//  tx_valid    in   1   byte available
//  tx_ready    out  1   block can accept a byte
//  l_out       out  12  duty value to SwiptOut
//  busy        out  1   frame in progress
//  frame_done  out  1   1-cycle pulse, frame completed
//  aborted     out  1   1-cycle pulse, frame abandoned
// BEHAVIOUR
//  Reset (nrst low, async): state IDLE, l_out=DEFAULT_L, tx_ready=0, busy=0, frame_done=0, aborted=0, counters 0.
//  States: IDLE -> PREAMBLE -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE: l_out <= base_l each cycle (1-cycle latency); tx_ready = enable & swiptAlive (registered outputs, combinational ready allowed).
//  Accept: tx_valid & tx_ready at edge N latches tx_data, base_l, delta_l; inputs changes after N are ignored until IDLE.
//  Edge N+1: state PREAMBLE, busy=1, tx_ready=0, l_out = first symbol level.
//  Symbol levels: '1' -> hi = min(base+delta, 12'hFFF); '0' -> lo = max(base-delta, 0); use 13-bit intermediates, saturate.
//  STOP symbol level = latched base. Every symbol holds exactly BIT_CYCLES cycles.
//  Frame length = (PREAMBLE_BITS + 8 + P + 1) * BIT_CYCLES cycles, P = 1 with parity else 0.
//  End: cycle after last STOP cycle -> IDLE, busy=0, frame_done=1 for one cycle, tx_ready may reassert same cycle.
//  Back-to-back: byte accepted on the frame_done cycle starts next frame on the following edge; no idle symbol inserted.
//  Abort: enable or swiptAlive low in any non-IDLE state -> next edge IDLE, l_out=base_l (live input), aborted=1 one cycle, no frame_done.
//  Abort and tx_valid same cycle: abort wins, byte not accepted.
//  delta_l=0: frame still runs full length, l_out constant at base.
//  base_l/delta_l change mid-frame: no effect on current frame.
// CONFIGURATION
//  SWIPT_TX_PARITY_EN defined: PARITY state after DATA sends even parity (XOR of 8 data bits); P=1.
//  Not defined: DATA -> STOP directly; P=0; no parity logic synthesised.
// TESTING (BIT_CYCLES=4, PREAMBLE_BITS=4, base=0x100, delta=0x040)
//  Reset: nrst low mid-run -> l_out=0x0C8, busy=0, tx_ready=0 immediately (async).
//  Send 0xA5, no parity -> l_out per 4-cycle symbol: 140,0C0,140,0C0 | 140,0C0,140,0C0,0C0,140,0C0,140 | 100; frame_done 52 cycles after accept.
//  Send 0xA5 with SWIPT_TX_PARITY_EN -> parity symbol 0x0C0 after data, frame_done at 56 cycles.
//  Saturation: base=0xFF0, delta=0x040, byte 0x01 -> '1' symbols 0xFFF; base=0x020 -> '0' symbols 0x000.
//  Abort: drop swiptAlive in 3rd data symbol -> next edge IDLE, aborted pulse, l_out=base, no frame_done.
//  Back-to-back: tx_valid held with 0x3C then 0xC3 -> second preamble starts cycle after frame_done, no gap.

Source files
------------

// File: rtl/swipt_duty_tx.sv
// SWIPT duty-cycle data transmitter.
// Sends each byte as a frame of duty-cycle (l) steps on the power carrier:
// alternating preamble, 8 data bits LSB first, optional even-parity bit, and a
// stop symbol at the base level. Each symbol holds for BIT_CYCLES clocks.
// Build option: define SWIPT_TX_PARITY_EN to add the even-parity symbol.
`timescale 1ns/1ps

module swipt_duty_tx #(
  parameter int unsigned BIT_CYCLES    = 1000,
  parameter int unsigned PREAMBLE_BITS = 4,
  parameter logic [11:0] DEFAULT_L     = 12'hC8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic        enable,
  input  logic [11:0] base_l,
  input  logic [11:0] delta_l,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [11:0] l_out,
  output logic        busy,
  output logic        frame_done,
  output logic        aborted
);

  localparam int unsigned CNT_W   = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IDX_MAX = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
`ifdef SWIPT_TX_PARITY_EN
    ST_PARITY   = 3'd3,
`endif
    ST_STOP     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         data_q, data_d;
  logic [11:0]        base_q, base_d;
  logic [11:0]        delta_q, delta_d;
  logic [11:0]        l_out_q, l_out_d;
  logic               tx_ready_q, tx_ready_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               aborted_q, aborted_d;

  logic               link_ok;
  logic               sym_end;
  logic [11:0]        hi, lo;
  logic [2:0]         data_nxt;

  // Saturating '1' level: min(base + delta, 0xFFF) via a 13-bit sum.
  function automatic logic [11:0] sat_hi(input logic [11:0] b, input logic [11:0] d);
    logic [12:0] s;
    s = {1'b0, b} + {1'b0, d};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

  // Saturating '0' level: max(base - delta, 0); bit 12 is the borrow.
  function automatic logic [11:0] sat_lo(input logic [11:0] b, input logic [11:0] d);
    logic [12:0] s;
    s = {1'b0, b} - {1'b0, d};
    return s[12] ? 12'h000 : s[11:0];
  endfunction

  // Next-state, symbol sequencing and output levels.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    idx_d        = idx_q;
    data_d       = data_q;
    base_d       = base_q;
    delta_d      = delta_q;
    l_out_d      = l_out_q;
    busy_d       = busy_q;
    tx_ready_d   = 1'b0;
    frame_done_d = 1'b0;
    aborted_d    = 1'b0;

    link_ok  = enable & swiptAlive;
    sym_end  = (cyc_q == CNT_W'(BIT_CYCLES - 1));
    hi       = sat_hi(base_q, delta_q);
    lo       = sat_lo(base_q, delta_q);
    data_nxt = 3'(idx_q) + 3'd1;

    case (state_q)
      ST_IDLE: begin
        cyc_d   = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
        l_out_d = base_l;
        if (tx_valid && tx_ready_q && link_ok) begin
          // Accept: freeze frame parameters; first preamble symbol is a '1'.
          state_d = ST_PREAMBLE;
          data_d  = tx_data;
          base_d  = base_l;
          delta_d = delta_l;
          busy_d  = 1'b1;
          l_out_d = sat_hi(base_l, delta_l);
        end else begin
          tx_ready_d = link_ok;
        end
      end

      default: begin
        if (!link_ok) begin
          // Carrier lost or disabled: drop the frame and return to idle level.
          state_d   = ST_IDLE;
          cyc_d     = '0;
          idx_d     = '0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          l_out_d   = base_l;
        end else if (!sym_end) begin
          cyc_d = cyc_q + CNT_W'(1);
        end else begin
          cyc_d = '0;
          case (state_q)
            ST_PREAMBLE: begin
              if (idx_q == IDX_W'(PREAMBLE_BITS - 1)) begin
                state_d = ST_DATA;
                idx_d   = '0;
                l_out_d = data_q[0] ? hi : lo;
              end else begin
                idx_d   = idx_q + IDX_W'(1);
                l_out_d = idx_q[0] ? hi : lo;
              end
            end
            ST_DATA: begin
              if (idx_q == IDX_W'(7)) begin
                idx_d   = '0;
`ifdef SWIPT_TX_PARITY_EN
                state_d = ST_PARITY;
                l_out_d = (^data_q) ? hi : lo;
`else
                state_d = ST_STOP;
                l_out_d = base_q;
`endif
              end else begin
                idx_d   = idx_q + IDX_W'(1);
                l_out_d = data_q[data_nxt] ? hi : lo;
              end
            end
`ifdef SWIPT_TX_PARITY_EN
            ST_PARITY: begin
              state_d = ST_STOP;
              l_out_d = base_q;
            end
`endif
            ST_STOP: begin
              state_d      = ST_IDLE;
              busy_d       = 1'b0;
              frame_done_d = 1'b1;
              tx_ready_d   = 1'b1;
              l_out_d      = base_l;
            end
            default: begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              l_out_d = base_l;
            end
          endcase
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      base_q       <= '0;
      delta_q      <= '0;
      l_out_q      <= DEFAULT_L;
      tx_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      base_q       <= base_d;
      delta_q      <= delta_d;
      l_out_q      <= l_out_d;
      tx_ready_q   <= tx_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign tx_ready   = tx_ready_q;
  assign l_out      = l_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_swipt_duty_tx.sv
// Directed bench for swipt_duty_tx with BIT_CYCLES=4, PREAMBLE_BITS=4.
`timescale 1ns/1ps

module tb_swipt_duty_tx;

  localparam int unsigned BC = 4;
`ifdef SWIPT_TX_PARITY_EN
  localparam int unsigned NSYM = 14;
`else
  localparam int unsigned NSYM = 13;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        swiptAlive;
  logic        enable;
  logic [11:0] base_l;
  logic [11:0] delta_l;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [11:0] l_out;
  logic        busy;
  logic        frame_done;
  logic        aborted;

  int n_cmp = 0;
  int n_mis = 0;

  swipt_duty_tx #(
    .BIT_CYCLES   (BC),
    .PREAMBLE_BITS(4),
    .DEFAULT_L    (12'h0C8)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .swiptAlive(swiptAlive),
    .enable    (enable),
    .base_l    (base_l),
    .delta_l   (delta_l),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .l_out     (l_out),
    .busy      (busy),
    .frame_done(frame_done),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected level of symbol s of a frame carrying byte b.
  function automatic logic [11:0] exp_sym(input logic [7:0] b, input logic [11:0] hi,
                                          input logic [11:0] lo, input logic [11:0] stp,
                                          input int s);
    if (s < 4) return (s % 2 == 0) ? hi : lo;
    if (s < 12) return b[s-4] ? hi : lo;
`ifdef SWIPT_TX_PARITY_EN
    if (s == 12) return (^b) ? hi : lo;
`endif
    return stp;
  endfunction

  // Wait (bounded) until tx_ready is seen high at a falling edge.
  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) chk("ready_timeout", 32'(tx_ready), 32'd1);
  endtask

  // Called right after the accepting edge; walks the frame and the done cycle.
  task automatic frame_check(input logic [7:0] b, input logic [11:0] hi, input logic [11:0] lo,
                             input logic [11:0] stp, input logic [11:0] idle_l);
    for (int c = 0; c < int'(NSYM * BC); c++) begin
      @(negedge clk);
      chk("l_out_sym", 32'(l_out), 32'(exp_sym(b, hi, lo, stp, c / int'(BC))));
      chk("busy_in_frame", 32'(busy), 32'd1);
      chk("done_early", 32'(frame_done), 32'd0);
    end
    @(negedge clk);
    chk("frame_done", 32'(frame_done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("l_out_end", 32'(l_out), 32'(idle_l));
    chk("ready_end", 32'(tx_ready), 32'd1);
    chk("aborted_end", 32'(aborted), 32'd0);
  endtask

  // Send one byte; base/delta are scrambled mid-frame and must not matter.
  task automatic send(input logic [7:0] b, input logic [11:0] bs, input logic [11:0] dl,
                      input logic [11:0] hi, input logic [11:0] lo);
    base_l   = bs;
    delta_l  = dl;
    tx_data  = b;
    tx_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    base_l   = 12'h7AB;
    delta_l  = 12'h3FF;
    frame_check(b, hi, lo, bs, 12'h7AB);
  endtask

  initial begin
    logic seen_done;
    nrst       = 1'b0;
    swiptAlive = 1'b1;
    enable     = 1'b1;
    base_l     = 12'h100;
    delta_l    = 12'h040;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;

    // Reset state
    #12;
    chk("rst_l_out", 32'(l_out), 32'h0C8);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_abort", 32'(aborted), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("idle_l_out", 32'(l_out), 32'h100);
    chk("idle_ready", 32'(tx_ready), 32'd1);

    // Disabled idle deasserts ready
    enable = 1'b0;
    @(negedge clk);
    chk("idle_ready_dis", 32'(tx_ready), 32'd0);
    enable = 1'b1;
    @(negedge clk);

    // Main frames
    send(8'hA5, 12'h100, 12'h040, 12'h140, 12'h0C0);
    send(8'h01, 12'hFF0, 12'h040, 12'hFFF, 12'hFB0);
    send(8'h01, 12'h020, 12'h040, 12'h060, 12'h000);
    send(8'h5A, 12'h100, 12'h000, 12'h100, 12'h100);

    // Abort in third data symbol
    base_l   = 12'h100;
    delta_l  = 12'h040;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    base_l   = 12'h123;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      chk("abort_l_out", 32'(l_out), 32'(exp_sym(8'hA5, 12'h140, 12'h0C0, 12'h100, c / int'(BC))));
    end
    swiptAlive = 1'b0;
    tx_valid   = 1'b1;
    @(negedge clk);
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_l_out_base", 32'(l_out), 32'h123);
    chk("abort_no_done", 32'(frame_done), 32'd0);
    chk("abort_ready", 32'(tx_ready), 32'd0);
    seen_done = 1'b0;
    @(negedge clk);
    chk("abort_one_cycle", 32'(aborted), 32'd0);
    chk("abort_no_accept", 32'(busy), 32'd0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (frame_done) seen_done = 1'b1;
    end
    chk("abort_never_done", 32'(seen_done), 32'd0);
    tx_valid   = 1'b0;
    swiptAlive = 1'b1;
    base_l     = 12'h100;
    @(negedge clk);

    // Back-to-back frames, tx_valid held
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    tx_data = 8'hC3;
    frame_check(8'h3C, 12'h140, 12'h0C0, 12'h100, 12'h100);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    frame_check(8'hC3, 12'h140, 12'h0C0, 12'h100, 12'h100);

    // Asynchronous reset in mid-frame
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_l_out", 32'(l_out), 32'h0C8);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    chk("async_hold_l_out", 32'(l_out), 32'h0C8);
    nrst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(tx_ready), 32'd1);
    chk("post_rst_l_out", 32'(l_out), 32'h100);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
